// File: rtl/alu_reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
package alu_reservation_station_pkg;

  localparam int CSU_SIZE_BITS = 4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic                     valid;
    logic [CSU_SIZE_BITS-1:0] ins_id;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [31:0]              imm_val;
    logic [5:0]               shamt_val;
    logic [31:0]              request_pc;
    logic                     is_compressed;
    logic                     rs1_rdy;
    logic [31:0]              rs1_val;
    logic [CSU_SIZE_BITS-1:0] rs1_tag;
    logic                     rs2_rdy;
    logic [31:0]              rs2_val;
    logic [CSU_SIZE_BITS-1:0] rs2_tag;
  } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_rs_issue_picker.sv
// Lowest-index priority encoder: reports whether any request is set and the
// index of the lowest one.
module rs_issue_picker #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  // scan high to low so the lowest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched instructions, snoops the ALU and
// load broadcast buses for missing operands, and issues the lowest-index ready
// entry to the ALU once per cycle.
// Optional feature: define ALU_RS_FAST_WAKEUP_EN to let a same-cycle broadcast
// make an entry eligible for select (back-to-back dependent issue).
module alu_reservation_station #(
  parameter int RS_SIZE       = 8,
  parameter int CSU_SIZE_BITS = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_pipline,
  input  logic                     disp_valid,
  input  logic [CSU_SIZE_BITS-1:0] disp_ins_id,
  input  logic [6:0]               disp_opcode,
  input  logic [2:0]               disp_funct3,
  input  logic [6:0]               disp_funct7,
  input  logic [31:0]              disp_imm_val,
  input  logic [5:0]               disp_shamt_val,
  input  logic [31:0]              disp_request_PC,
  input  logic                     disp_is_compressed,
  input  logic                     disp_rs1_rdy,
  input  logic                     disp_rs2_rdy,
  input  logic [31:0]              disp_rs1_val,
  input  logic [31:0]              disp_rs2_val,
  input  logic [CSU_SIZE_BITS-1:0] disp_rs1_tag,
  input  logic [CSU_SIZE_BITS-1:0] disp_rs2_tag,
  output logic                     rs_full,
  input  logic                     alu_bc_valid,
  input  logic [CSU_SIZE_BITS-1:0] alu_bc_id,
  input  logic [31:0]              alu_bc_val,
  input  logic                     mem_bc_valid,
  input  logic [CSU_SIZE_BITS-1:0] mem_bc_id,
  input  logic [31:0]              mem_bc_val,
  output logic                     have_ins,
  output logic [CSU_SIZE_BITS-1:0] ins_id,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic [31:0]              imm_val,
  output logic [5:0]               shamt_val,
  output logic [6:0]               opcode,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [31:0]              request_PC,
  output logic                     is_compressed_ins
);
  import alu_reservation_station_pkg::*;

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry_t          entry_q [RS_SIZE];
  rs_entry_t          woke    [RS_SIZE];
  rs_entry_t          cand    [RS_SIZE];
  rs_entry_t          disp_entry;
  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found;
  logic               sel_found;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      sel_idx;

  // {rdy, val} after snooping both buses; ALU result wins over a load result
  function automatic logic [32:0] snoop(input logic rdy, input logic [31:0] val,
                                        input logic [CSU_SIZE_BITS-1:0] tag);
    if (rdy) return {1'b1, val};
    if (alu_bc_valid && (alu_bc_id == tag)) return {1'b1, alu_bc_val};
    if (mem_bc_valid && (mem_bc_id == tag)) return {1'b1, mem_bc_val};
    return {1'b0, val};
  endfunction

  // per-entry wakeup and the view used by select (pre- or post-wakeup)
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      woke[i] = entry_q[i];
      {woke[i].rs1_rdy, woke[i].rs1_val} =
        snoop(entry_q[i].rs1_rdy, entry_q[i].rs1_val, entry_q[i].rs1_tag);
      {woke[i].rs2_rdy, woke[i].rs2_val} =
        snoop(entry_q[i].rs2_rdy, entry_q[i].rs2_val, entry_q[i].rs2_tag);
`ifdef ALU_RS_FAST_WAKEUP_EN
      cand[i] = woke[i];
`else
      cand[i] = entry_q[i];
`endif
      free_vec[i]  = ~entry_q[i].valid;
      ready_vec[i] = cand[i].valid & cand[i].rs1_rdy & cand[i].rs2_rdy;
    end
  end

  // incoming entry, with same-cycle broadcast capture on its operands
  always_comb begin
    disp_entry               = '0;
    disp_entry.valid         = 1'b1;
    disp_entry.ins_id        = disp_ins_id;
    disp_entry.opcode        = disp_opcode;
    disp_entry.funct3        = disp_funct3;
    disp_entry.funct7        = disp_funct7;
    disp_entry.imm_val       = disp_imm_val;
    disp_entry.shamt_val     = disp_shamt_val;
    disp_entry.request_pc    = disp_request_PC;
    disp_entry.is_compressed = disp_is_compressed;
    disp_entry.rs1_tag       = disp_rs1_tag;
    disp_entry.rs2_tag       = disp_rs2_tag;
    {disp_entry.rs1_rdy, disp_entry.rs1_val} = snoop(disp_rs1_rdy, disp_rs1_val, disp_rs1_tag);
    {disp_entry.rs2_rdy, disp_entry.rs2_val} = snoop(disp_rs2_rdy, disp_rs2_val, disp_rs2_tag);
  end

  rs_issue_picker #(.N(RS_SIZE), .IW(IW)) u_free_pick (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_issue_picker #(.N(RS_SIZE), .IW(IW)) u_ready_pick (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // full is derived from registered valid bits only
  assign rs_full = ~|free_vec;

  // entry storage, issue registers; flush beats issue and dispatch
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= '0;
      have_ins          <= 1'b0;
      ins_id            <= '0;
      rs1_val           <= '0;
      rs2_val           <= '0;
      imm_val           <= '0;
      shamt_val         <= '0;
      opcode            <= '0;
      funct3            <= '0;
      funct7            <= '0;
      request_PC        <= '0;
      is_compressed_ins <= 1'b0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        for (int i = 0; i < RS_SIZE; i++) entry_q[i].valid <= 1'b0;
        have_ins <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= woke[i];
        have_ins <= sel_found;
        if (sel_found) begin
          entry_q[sel_idx].valid <= 1'b0;
          ins_id            <= cand[sel_idx].ins_id;
          rs1_val           <= cand[sel_idx].rs1_val;
          rs2_val           <= cand[sel_idx].rs2_val;
          imm_val           <= cand[sel_idx].imm_val;
          shamt_val         <= cand[sel_idx].shamt_val;
          opcode            <= cand[sel_idx].opcode;
          funct3            <= cand[sel_idx].funct3;
          funct7            <= cand[sel_idx].funct7;
          request_PC        <= cand[sel_idx].request_pc;
          is_compressed_ins <= cand[sel_idx].is_compressed;
        end
        if (disp_valid && free_found) entry_q[free_idx] <= disp_entry;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed vectors, corner
// sequences and randomized traffic against a behavioural reference model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int RS = 8;
`ifdef ALU_RS_FAST_WAKEUP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int EXP_LAT = FAST ? 1 : 2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_pipline;
  logic        disp_valid;
  logic [3:0]  disp_ins_id;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_funct3;
  logic [6:0]  disp_funct7;
  logic [31:0] disp_imm_val;
  logic [5:0]  disp_shamt_val;
  logic [31:0] disp_request_PC;
  logic        disp_is_compressed;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_val, disp_rs2_val;
  logic [3:0]  disp_rs1_tag, disp_rs2_tag;
  logic        rs_full;
  logic        alu_bc_valid, mem_bc_valid;
  logic [3:0]  alu_bc_id, mem_bc_id;
  logic [31:0] alu_bc_val, mem_bc_val;
  logic        have_ins;
  logic [3:0]  ins_id;
  logic [31:0] rs1_val, rs2_val, imm_val, request_PC;
  logic [5:0]  shamt_val;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        is_compressed_ins;

  int checks = 0;
  int errors = 0;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .disp_valid(disp_valid), .disp_ins_id(disp_ins_id), .disp_opcode(disp_opcode),
    .disp_funct3(disp_funct3), .disp_funct7(disp_funct7), .disp_imm_val(disp_imm_val),
    .disp_shamt_val(disp_shamt_val), .disp_request_PC(disp_request_PC),
    .disp_is_compressed(disp_is_compressed), .disp_rs1_rdy(disp_rs1_rdy),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag), .rs_full(rs_full),
    .alu_bc_valid(alu_bc_valid), .alu_bc_id(alu_bc_id), .alu_bc_val(alu_bc_val),
    .mem_bc_valid(mem_bc_valid), .mem_bc_id(mem_bc_id), .mem_bc_val(mem_bc_val),
    .have_ins(have_ins), .ins_id(ins_id), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm_val(imm_val), .shamt_val(shamt_val), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .request_PC(request_PC), .is_compressed_ins(is_compressed_ins)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        v;
    logic [3:0]  id;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [5:0]  sh;
    logic [31:0] pc;
    logic        c;
    logic        r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic        r2;
    logic [31:0] v2;
    logic [3:0]  t2;
  } m_ent_t;

  m_ent_t m [RS];
  m_ent_t e_out;
  logic   e_have;

  function automatic logic [32:0] m_snoop(input logic r, input logic [31:0] v, input logic [3:0] t);
    if (r) return {1'b1, v};
    if (alu_bc_valid && alu_bc_id == t) return {1'b1, alu_bc_val};
    if (mem_bc_valid && mem_bc_id == t) return {1'b1, mem_bc_val};
    return {1'b0, v};
  endfunction

  function automatic m_ent_t m_wake(input m_ent_t e);
    m_ent_t r = e;
    {r.r1, r.v1} = m_snoop(e.r1, e.v1, e.t1);
    {r.r2, r.v2} = m_snoop(e.r2, e.v2, e.t2);
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < RS; i++) m[i] = '0;
    e_out  = '0;
    e_have = 1'b0;
  endtask

  function automatic bit m_full();
    for (int i = 0; i < RS; i++) if (!m[i].v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    m_ent_t nx [RS];
    m_ent_t view [RS];
    m_ent_t ne;
    int pick = -1;
    int slot = -1;
    bit full;
    if (!rdy_in) return;
    if (flush_pipline) begin
      for (int i = 0; i < RS; i++) m[i].v = 1'b0;
      e_have = 1'b0;
      return;
    end
    full = m_full();
    for (int i = 0; i < RS; i++) begin
      nx[i]   = m[i].v ? m_wake(m[i]) : m[i];
      view[i] = FAST ? nx[i] : m[i];
    end
    for (int i = 0; i < RS; i++)
      if (pick < 0 && view[i].v && view[i].r1 && view[i].r2) pick = i;
    e_have = (pick >= 0);
    if (pick >= 0) begin
      e_out = view[pick];
      nx[pick].v = 1'b0;
    end
    if (disp_valid && !full) begin
      for (int i = 0; i < RS; i++) if (slot < 0 && !m[i].v) slot = i;
      ne = '{v: 1'b1, id: disp_ins_id, op: disp_opcode, f3: disp_funct3, f7: disp_funct7,
             imm: disp_imm_val, sh: disp_shamt_val, pc: disp_request_PC, c: disp_is_compressed,
             r1: disp_rs1_rdy, v1: disp_rs1_val, t1: disp_rs1_tag,
             r2: disp_rs2_rdy, v2: disp_rs2_val, t2: disp_rs2_tag};
      nx[slot] = m_wake(ne);
    end
    for (int i = 0; i < RS; i++) m[i] = nx[i];
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("have_ins", {31'b0, have_ins}, {31'b0, e_have});
    chk("rs_full", {31'b0, rs_full}, {31'b0, m_full()});
    chk("ins_id", {28'b0, ins_id}, {28'b0, e_out.id});
    chk("rs1_val", rs1_val, e_out.v1);
    chk("rs2_val", rs2_val, e_out.v2);
    chk("imm_val", imm_val, e_out.imm);
    chk("shamt_val", {26'b0, shamt_val}, {26'b0, e_out.sh});
    chk("opcode", {25'b0, opcode}, {25'b0, e_out.op});
    chk("funct3", {29'b0, funct3}, {29'b0, e_out.f3});
    chk("funct7", {25'b0, funct7}, {25'b0, e_out.f7});
    chk("request_PC", request_PC, e_out.pc);
    chk("is_compressed", {31'b0, is_compressed_ins}, {31'b0, e_out.c});
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (rst_in) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; flush_pipline = 1'b0; disp_valid = 1'b0;
    alu_bc_valid = 1'b0; alu_bc_id = '0; alu_bc_val = '0;
    mem_bc_valid = 1'b0; mem_bc_id = '0; mem_bc_val = '0;
  endtask

  task automatic set_disp(input logic [3:0] id, input logic [6:0] op, input logic [31:0] imm,
                          input logic r1r, input logic [31:0] r1v, input logic [3:0] r1t,
                          input logic r2r, input logic [31:0] r2v, input logic [3:0] r2t);
    disp_valid = 1'b1; disp_ins_id = id; disp_opcode = op;
    disp_funct3 = id[2:0]; disp_funct7 = {3'b0, id}; disp_imm_val = imm;
    disp_shamt_val = {2'b0, id}; disp_request_PC = 32'h1000 + {28'b0, id} * 4;
    disp_is_compressed = id[0];
    disp_rs1_rdy = r1r; disp_rs1_val = r1v; disp_rs1_tag = r1t;
    disp_rs2_rdy = r2r; disp_rs2_val = r2v; disp_rs2_tag = r2t;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    m_reset();
    #1;
    compare_all();
    tick();
    tick();
    rst_in = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [6:0]  op;
    logic [31:0] imm;
    logic        r1r; logic [31:0] r1v; logic [3:0] r1t;
    logic        r2r; logic [31:0] r2v; logic [3:0] r2t;
    logic        av;  logic [3:0]  aid; logic [31:0] aval;
    logic        mv;  logic [3:0]  mid; logic [31:0] mval;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vt [7];
  int   lat;

  initial begin
    vt[0] = '{4'd1, OP_REG,    32'd0,   1, 32'h11, 4'd0, 1, 32'h22, 4'd0, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,    32'h11,   32'h22};
    vt[1] = '{4'd2, OP_REG,    32'd0,   1, 32'h1,  4'd0, 0, 32'h0,  4'd7, 0, 4'd0, 32'h0,    1, 4'd7, 32'hABCD, 32'h1,    32'hABCD};
    vt[2] = '{4'd3, OP_IMM,    32'd9,   0, 32'h0,  4'd3, 1, 32'h5,  4'd0, 1, 4'd3, 32'h1234, 0, 4'd0, 32'h0,    32'h1234, 32'h5};
    vt[3] = '{4'd4, OP_BRANCH, 32'h40,  0, 32'h0,  4'd9, 1, 32'h6,  4'd0, 1, 4'd9, 32'hAAAA, 1, 4'd9, 32'hBBBB, 32'hAAAA, 32'h6};
    vt[4] = '{4'd5, OP_REG,    32'd0,   0, 32'h0,  4'd5, 0, 32'h0,  4'd6, 1, 4'd5, 32'h55,   1, 4'd6, 32'h66,   32'h55,   32'h66};
    vt[5] = '{4'd6, OP_JALR,   32'd8,   1, 32'h77, 4'd2, 1, 32'h0,  4'd0, 1, 4'd2, 32'h99,   0, 4'd0, 32'h0,    32'h77,   32'h0};
    vt[6] = '{4'd7, OP_REG,    32'd0,   0, 32'h0,  4'd4, 0, 32'h0,  4'd4, 1, 4'd4, 32'hC0DE, 0, 4'd0, 32'h0,    32'hC0DE, 32'hC0DE};

    // reset held while dispatch is active
    idle_inputs();
    m_reset();
    rst_in = 1'b0;
    set_disp(4'd9, OP_IMM, 32'd1, 1, 32'd1, 4'd0, 1, 32'd0, 4'd0);
    tick();
    tick();
    chk("reset_have", {31'b0, have_ins}, 32'd0);
    chk("reset_full", {31'b0, rs_full}, 32'd0);
    disp_valid = 1'b0;
    rst_in = 1'b1;
    tick();

    // ADDI with rs1=5 ready, imm=3
    set_disp(4'd1, OP_IMM, 32'd3, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0);
    tick();
    disp_valid = 1'b0;
    tick();
    chk("addi_have", {31'b0, have_ins}, 32'd1);
    chk("addi_rs1", rs1_val, 32'd5);
    chk("addi_imm", imm_val, 32'd3);
    chk("addi_id", {28'b0, ins_id}, 32'd1);
    tick();

    // table: dispatch with same-cycle broadcasts, expect issue next edge
    for (int k = 0; k < 7; k++) begin
      set_disp(vt[k].id, vt[k].op, vt[k].imm, vt[k].r1r, vt[k].r1v, vt[k].r1t,
               vt[k].r2r, vt[k].r2v, vt[k].r2t);
      alu_bc_valid = vt[k].av; alu_bc_id = vt[k].aid; alu_bc_val = vt[k].aval;
      mem_bc_valid = vt[k].mv; mem_bc_id = vt[k].mid; mem_bc_val = vt[k].mval;
      tick();
      idle_inputs();
      tick();
      chk("vec_have", {31'b0, have_ins}, 32'd1);
      chk("vec_id", {28'b0, ins_id}, {28'b0, vt[k].id});
      chk("vec_rs1", rs1_val, vt[k].e1);
      chk("vec_rs2", rs2_val, vt[k].e2);
      tick();
    end

    // dependency wakeup latency
    set_disp(4'd3, OP_REG, 32'd0, 0, 32'd0, 4'd2, 1, 32'd1, 4'd0);
    tick();
    idle_inputs();
    tick();
    alu_bc_valid = 1'b1; alu_bc_id = 4'd2; alu_bc_val = 32'h10;
    tick();
    idle_inputs();
    lat = 1;
    while (have_ins !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    chk("dep_latency", lat, EXP_LAT);
    chk("dep_rs1", rs1_val, 32'h10);
    tick();

    // fill the station, attempt a ninth, then wake entry 3
    for (int i = 0; i < 8; i++) begin
      set_disp(4'(i), OP_REG, 32'd0, 0, 32'd0, 4'(8 + i), 1, 32'd2, 4'd0);
      tick();
    end
    idle_inputs();
    chk("full_set", {31'b0, rs_full}, 32'd1);
    set_disp(4'd9, OP_IMM, 32'd0, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0);
    tick();
    idle_inputs();
    tick();
    tick();
    chk("ninth_ignored", {31'b0, have_ins}, 32'd0);
    alu_bc_valid = 1'b1; alu_bc_id = 4'd11; alu_bc_val = 32'h333;
    tick();
    idle_inputs();
    lat = 1;
    while (have_ins !== 1'b1 && lat < 6) begin
      tick();
      lat++;
    end
    chk("full_wake_lat", lat, EXP_LAT);
    chk("full_wake_id", {28'b0, ins_id}, 32'd3);
    chk("full_wake_rs1", rs1_val, 32'h333);
    chk("full_drop", {31'b0, rs_full}, 32'd0);
    tick();
    do_reset();
    tick();
    chk("reset_mid_full", {31'b0, rs_full}, 32'd0);

    // flush in the cycle the entries would first issue
    for (int i = 0; i < 4; i++) begin
      set_disp(4'(i), OP_REG, 32'd0, 0, 32'd0, 4'd5, 1, 32'd3, 4'd0);
      tick();
    end
    idle_inputs();
    alu_bc_valid = 1'b1; alu_bc_id = 4'd5; alu_bc_val = 32'h50;
    if (!FAST) begin
      tick();
      idle_inputs();
    end
    flush_pipline = 1'b1;
    tick();
    idle_inputs();
    chk("flush_have", {31'b0, have_ins}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flush_no_issue", {31'b0, have_ins}, 32'd0);
    end

    // stall with a ready entry and an active broadcast
    do_reset();
    set_disp(4'd5, OP_REG, 32'd0, 0, 32'd0, 4'd6, 1, 32'd7, 4'd0);
    tick();
    set_disp(4'd4, OP_IMM, 32'd12, 1, 32'h44, 4'd0, 1, 32'd0, 4'd0);
    tick();
    idle_inputs();
    rdy_in = 1'b0;
    alu_bc_valid = 1'b1; alu_bc_id = 4'd6; alu_bc_val = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_have", {31'b0, have_ins}, 32'd0);
      chk("stall_id", {28'b0, ins_id}, 32'd0);
      chk("stall_rs1", rs1_val, 32'd0);
    end
    idle_inputs();
    tick();
    chk("stall_resume", {31'b0, have_ins}, 32'd1);
    chk("stall_resume_id", {28'b0, ins_id}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_bc_ignored", {31'b0, have_ins}, 32'd0);
    end
    do_reset();

    // randomized traffic against the model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 750) do_reset();
      rdy_in        = ($urandom_range(0, 7) != 0);
      flush_pipline = ($urandom_range(0, 59) == 0);
      disp_valid    = $urandom_range(0, 1) == 1;
      disp_ins_id = 4'($urandom); disp_opcode = 7'($urandom); disp_funct3 = 3'($urandom);
      disp_funct7 = 7'($urandom); disp_imm_val = $urandom; disp_shamt_val = 6'($urandom);
      disp_request_PC = $urandom; disp_is_compressed = 1'($urandom);
      disp_rs1_rdy = ($urandom_range(0, 2) == 0); disp_rs1_val = $urandom; disp_rs1_tag = 4'($urandom);
      disp_rs2_rdy = ($urandom_range(0, 2) == 0); disp_rs2_val = $urandom; disp_rs2_tag = 4'($urandom);
      alu_bc_valid = ($urandom_range(0, 9) < 4); alu_bc_id = 4'($urandom); alu_bc_val = $urandom;
      mem_bc_valid = ($urandom_range(0, 9) < 3); mem_bc_id = 4'($urandom); mem_bc_val = $urandom;
      tick();
    end
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
